// File: rtl/z80_io_pkg.sv
// Shared definitions for the Z80 I/O-space responder: register offsets,
// STATUS bit positions and the wait-state FSM encoding.
package z80_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_VECTOR = 2'd2;

    localparam int unsigned ST_RX_FULL     = 0;
    localparam int unsigned ST_TX_NOT_FULL = 1;
    localparam int unsigned ST_TX_EMPTY    = 2;
    localparam int unsigned ST_OVF         = 3;
    localparam int unsigned ST_INT_EN      = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_HOLD = 2'd2
    } wait_state_t;

    // Assemble the STATUS read value; bits [7:5] read as zero.
    function automatic logic [7:0] status_byte(
        input logic rx_full,
        input logic tx_not_full,
        input logic tx_empty,
        input logic ovf,
        input logic int_en
    );
        logic [7:0] s;
        s = 8'h00;
        s[ST_RX_FULL]     = rx_full;
        s[ST_TX_NOT_FULL] = tx_not_full;
        s[ST_TX_EMPTY]    = tx_empty;
        s[ST_OVF]         = ovf;
        s[ST_INT_EN]      = int_en;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; a push into a full FIFO is discarded here.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since empty gates the output.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-space peripheral: console DATA/STATUS/VECTOR registers at BASE,
// programmable wait states and mode-2 interrupt-acknowledge vector.
module z80_io_responder
    import z80_io_pkg::*;
#(
    parameter logic [7:0]  BASE        = 8'h10,
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        eclk,
    input  logic        ereset,
    input  logic        clk,
    input  logic [15:0] ab,
    input  logic [7:0]  db_o,
    output logic [7:0]  db_i,
    output logic        db_oe,
    input  logic        _iorq,
    input  logic        _rd,
    input  logic        _wr,
    input  logic        _m1,
    output logic        _wait,
    output logic        _int,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);

    // Registered bus samples and previous Z80 clock level.
    logic       clk_q, clk_p, iorq_q, rd_q, wr_q, m1_q;
    logic [7:0] ab_q, dbo_q;

    // Access tracking.
    logic       armed, acc_active, acc_rd;
    logic [1:0] acc_off;

    // Architectural registers.
    logic [7:0] rx_hold, vector;
    logic       rx_full, ovf, int_en;

    // Wait FSM.
    wait_state_t   wstate;
    logic [CW-1:0] wcnt;

    // TX FIFO status.
    logic tx_full, tx_empty;

    logic [7:0] off_c;
    logic       in_range_c, dec_c, inta_c, end_c, wr_cap_c, pop_rx_c;
    logic       clk_rise_c, rx_xfer_c, rx_full_next_c, tx_push_c;
    logic [7:0] rd_val_c;
    logic       unused_ab;

    // The upper address byte is not part of the port decode.
    assign unused_ab = ^ab[15:8];

    assign off_c      = ab_q - BASE;
    assign in_range_c = off_c < 8'd3;
    assign dec_c      = armed && !iorq_q && m1_q && (!rd_q || !wr_q) && in_range_c;
    assign inta_c     = armed && !iorq_q && !m1_q;
    assign end_c      = acc_active && (iorq_q || (acc_rd ? rd_q : wr_q));
    assign wr_cap_c   = end_c && !acc_rd && wr_q;
    assign pop_rx_c   = end_c && acc_rd && (acc_off == REG_DATA);
    assign clk_rise_c = clk_q && !clk_p;
    assign rx_xfer_c  = rx_valid && rx_ready;
    assign tx_push_c  = wr_cap_c && (acc_off == REG_DATA);

    assign rx_full_next_c = rx_xfer_c ? 1'b1 : (pop_rx_c ? 1'b0 : rx_full);

    // Read value selected at decode time.
    always_comb begin
        rd_val_c = 8'h00;
        case (off_c[1:0])
            REG_DATA:   rd_val_c = rx_hold;
            REG_STATUS: rd_val_c = status_byte(rx_full, !tx_full, tx_empty, ovf, int_en);
            REG_VECTOR: rd_val_c = vector;
            default:    rd_val_c = 8'h00;
        endcase
    end

    // Pin sampling; left unreset so a cycle in flight across reset stays visible.
    always_ff @(posedge eclk) begin
        clk_q  <= clk;
        clk_p  <= clk_q;
        iorq_q <= _iorq;
        rd_q   <= _rd;
        wr_q   <= _wr;
        m1_q   <= _m1;
        ab_q   <= ab[7:0];
        dbo_q  <= db_o;
    end

    // One decode per _iorq-low period; re-arm only once _iorq is seen high.
    always_ff @(posedge eclk) begin
        if (ereset) begin
            armed      <= 1'b0;
            acc_active <= 1'b0;
            acc_rd     <= 1'b0;
            acc_off    <= REG_DATA;
        end else if (dec_c) begin
            armed      <= 1'b0;
            acc_active <= 1'b1;
            acc_rd     <= !rd_q;
            acc_off    <= off_c[1:0];
        end else begin
            if (iorq_q) armed      <= 1'b1;
            if (end_c)  acc_active <= 1'b0;
        end
    end

    // Data bus drive for decoded reads and interrupt acknowledge.
    always_ff @(posedge eclk) begin
        if (ereset) begin
            db_i  <= 8'h00;
            db_oe <= 1'b0;
        end else if (inta_c) begin
            db_i  <= vector;
            db_oe <= 1'b1;
        end else if (dec_c && !rd_q) begin
            db_i  <= rd_val_c;
            db_oe <= 1'b1;
        end else if (db_oe && (iorq_q || rd_q)) begin
            db_i  <= 8'h00;
            db_oe <= 1'b0;
        end
    end

    // Register file, RX holding register and interrupt output.
    always_ff @(posedge eclk) begin
        if (ereset) begin
            rx_hold  <= 8'h00;
            rx_full  <= 1'b0;
            rx_ready <= 1'b1;
            ovf      <= 1'b0;
            int_en   <= 1'b0;
            vector   <= 8'h00;
            _int     <= 1'b1;
        end else begin
            if (rx_xfer_c) rx_hold <= rx_data;
            rx_full  <= rx_full_next_c;
            rx_ready <= !rx_full_next_c;
            _int     <= !(int_en && rx_full);
            if (tx_push_c && tx_full) ovf <= 1'b1;
            if (wr_cap_c && (acc_off == REG_STATUS)) begin
                int_en <= dbo_q[ST_INT_EN];
                if (dbo_q[ST_OVF]) ovf <= 1'b0;
            end
            if (wr_cap_c && (acc_off == REG_VECTOR)) vector <= dbo_q;
        end
    end

    // Wait-state FSM counting registered Z80 clock rises.
    always_ff @(posedge eclk) begin
        if (ereset) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            _wait  <= 1'b1;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (dec_c && (WAIT_CYCLES != 0)) begin
                        wstate <= W_WAIT;
                        wcnt   <= CW'(WAIT_CYCLES);
                        _wait  <= 1'b0;
                    end
                end
                W_WAIT: begin
                    if (iorq_q) begin
                        wstate <= W_IDLE;
                        _wait  <= 1'b1;
                    end else if (clk_rise_c) begin
                        wcnt <= wcnt - CW'(1);
                        if (wcnt == CW'(1)) begin
                            wstate <= W_HOLD;
                            _wait  <= 1'b1;
                        end
                    end
                end
                W_HOLD: begin
                    if (iorq_q) wstate <= W_IDLE;
                end
                default: begin
                    wstate <= W_IDLE;
                    _wait  <= 1'b1;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (eclk),
        .reset (ereset),
        .push  (tx_push_c),
        .din   (dbo_q),
        .pop   (tx_ready),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_valid = !tx_empty;

endmodule

// File: tb/tb_z80_io_responder.sv
// Bench for z80_io_responder: directed console scenarios followed by a
// random operation mix, all checked against a register-level model.
module tb_z80_io_responder;

    localparam logic [7:0]  BASE  = 8'h10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WAITS = 3;
    localparam int          LIMIT = 400;

    logic        eclk = 1'b0;
    logic        ereset = 1'b1;
    logic        z80_clk = 1'b0;
    logic [15:0] ab = 16'h0000;
    logic [7:0]  db_o = 8'h00;
    logic [7:0]  db_i;
    logic        db_oe;
    logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
    logic        wait_n, int_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int checks = 0;
    int failures = 0;
    int wait_rises = 0;

    // Reference model state.
    logic [7:0] m_tx[$];
    logic [7:0] got_tx[$];
    logic       m_ovf = 1'b0, m_int_en = 1'b0, m_rx_full = 1'b0;
    logic [7:0] m_rx = 8'h00, m_vec = 8'h00;

    z80_io_responder #(
        .BASE        (BASE),
        .TX_DEPTH    (DEPTH),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .eclk     (eclk),
        .ereset   (ereset),
        .clk      (z80_clk),
        .ab       (ab),
        .db_o     (db_o),
        .db_i     (db_i),
        .db_oe    (db_oe),
        ._iorq    (iorq_n),
        ._rd      (rd_n),
        ._wr      (wr_n),
        ._m1      (m1_n),
        ._wait    (wait_n),
        ._int     (int_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 eclk = ~eclk;

    initial begin
        #2;
        forever #40 z80_clk = ~z80_clk;
    end

    // Count Z80 clock rises that occur while _wait is asserted.
    always @(posedge z80_clk) begin
        #1;
        if (wait_n == 1'b0) wait_rises++;
    end

    // Record every TX handshake.
    always @(negedge eclk) begin
        #1;
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {3'b000, m_int_en, m_ovf, m_tx.size() == 0, m_tx.size() < int'(DEPTH), m_rx_full};
    endfunction

    task automatic model_reset();
        m_tx.delete();
        got_tx.delete();
        m_ovf = 1'b0;
        m_int_en = 1'b0;
        m_rx_full = 1'b0;
        m_rx = 8'h00;
        m_vec = 8'h00;
    endtask

    task automatic check_int();
        check("int", 16'(int_n), 16'(!(m_int_en && m_rx_full)));
        check("rx_ready", 16'(rx_ready), 16'(!m_rx_full));
    endtask

    // One IN/OUT cycle started just after a Z80 clock rise.
    task automatic bus(input logic is_rd, input logic [7:0] port, input logic [7:0] wdata,
                       output logic [7:0] rdata);
        logic [7:0] off;
        logic       hit;
        int         n;
        off = port - BASE;
        hit = off < 8'd3;
        @(posedge z80_clk);
        @(negedge eclk);
        ab = {8'($urandom), port};
        db_o = wdata;
        wait_rises = 0;
        iorq_n = 1'b0;
        if (is_rd) rd_n = 1'b0;
        else       wr_n = 1'b0;
        @(negedge eclk);
        check("wait_pre", 16'(wait_n), 16'd1);
        check("oe_pre", 16'(db_oe), 16'd0);
        @(negedge eclk);
        check("wait_dec", 16'(wait_n), 16'(!hit));
        check("oe_dec", 16'(db_oe), 16'(hit && is_rd));
        n = 0;
        while (wait_n == 1'b0 && n < LIMIT) begin
            @(negedge eclk);
            n++;
        end
        check("wait_bounded", 16'(n < LIMIT), 16'd1);
        repeat (2) @(negedge eclk);
        #1;
        rdata = db_i;
        check("oe_hold", 16'(db_oe), 16'(hit && is_rd));
        check("wait_rises", 16'(wait_rises), hit ? 16'(WAITS) : 16'd0);
        if (is_rd && hit && off == 8'd0)
            check("rx_ready_in_rd", 16'(rx_ready), 16'(!m_rx_full));
        @(negedge eclk);
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
        repeat (3) @(negedge eclk);
        check("oe_release", 16'(db_oe), 16'd0);
    endtask

    task automatic do_write(input logic [1:0] reg_i, input logic [7:0] d);
        logic [7:0] unused_rd;
        bus(1'b0, BASE + 8'(reg_i), d, unused_rd);
        case (reg_i)
            2'd0: if (m_tx.size() < int'(DEPTH)) m_tx.push_back(d); else m_ovf = 1'b1;
            2'd1: begin
                m_int_en = d[4];
                if (d[3]) m_ovf = 1'b0;
            end
            default: m_vec = d;
        endcase
    endtask

    task automatic do_read(input logic [1:0] reg_i);
        logic [7:0] r;
        logic [7:0] want;
        bus(1'b1, BASE + 8'(reg_i), 8'h00, r);
        case (reg_i)
            2'd0:    want = m_rx;
            2'd1:    want = m_status();
            default: want = m_vec;
        endcase
        check(reg_i == 2'd0 ? "rd_data" : (reg_i == 2'd1 ? "rd_status" : "rd_vector"),
              16'(r), 16'(want));
        if (reg_i == 2'd0) m_rx_full = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        if (m_rx_full) begin
            @(negedge eclk);
            #1;
            check("rx_stall", 16'(rx_ready), 16'd0);
        end else begin
            @(negedge eclk);
            rx_data = b;
            rx_valid = 1'b1;
            @(negedge eclk);
            rx_valid = 1'b0;
            m_rx_full = 1'b1;
            m_rx = b;
            @(negedge eclk);
        end
    endtask

    task automatic drain();
        @(negedge eclk);
        tx_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge eclk);
        tx_ready = 1'b0;
        @(negedge eclk);
        check("drain_count", 16'(got_tx.size()), 16'(m_tx.size()));
        for (int i = 0; i < m_tx.size(); i++) begin
            if (i < got_tx.size()) check("drain_byte", 16'(got_tx[i]), 16'(m_tx[i]));
        end
        check("drain_empty", 16'(tx_valid), 16'd0);
        m_tx.delete();
        got_tx.delete();
    endtask

    task automatic inta_cycle();
        @(negedge eclk);
        ab = 16'($urandom);
        m1_n = 1'b0;
        @(negedge eclk);
        iorq_n = 1'b0;
        repeat (3) @(negedge eclk);
        for (int i = 0; i < 2; i++) begin
            check("inta_oe", 16'(db_oe), 16'd1);
            check("inta_vec", 16'(db_i), 16'(m_vec));
            check("inta_wait", 16'(wait_n), 16'd1);
            @(negedge eclk);
        end
        iorq_n = 1'b1;
        m1_n = 1'b1;
        repeat (3) @(negedge eclk);
        check("inta_release", 16'(db_oe), 16'd0);
    endtask

    initial begin
        int n;
        int op;
        logic [7:0] r;

        repeat (5) @(negedge eclk);
        check("rst_db_i", 16'(db_i), 16'd0);
        check("rst_oe", 16'(db_oe), 16'd0);
        check("rst_wait", 16'(wait_n), 16'd1);
        check("rst_int", 16'(int_n), 16'd1);
        check("rst_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_rx_ready", 16'(rx_ready), 16'd1);
        ereset = 1'b0;
        repeat (3) @(negedge eclk);

        // Single byte out with the sink ready.
        tx_ready = 1'b1;
        do_write(2'd0, 8'h41);
        drain();
        do_read(2'd1);

        // Overflow, OVF clear, ordered drain.
        for (int i = 0; i < 5; i++) do_write(2'd0, 8'hA0 + 8'(i));
        do_read(2'd1);
        do_write(2'd1, 8'h08);
        do_read(2'd1);
        drain();

        // RX byte with interrupt enabled.
        do_write(2'd1, 8'h10);
        rx_send(8'h5A);
        check_int();
        do_read(2'd0);
        check_int();

        // Vector register and interrupt acknowledge.
        do_write(2'd2, 8'hE0);
        do_read(2'd2);
        inta_cycle();
        do_read(2'd1);

        // Out-of-range port: no wait, no drive.
        bus(1'b1, BASE + 8'd3, 8'h00, r);
        do_read(2'd1);

        // Reset during WAIT with an access in flight.
        do_write(2'd2, 8'hA5);
        rx_send(8'h77);
        do_write(2'd0, 8'h33);
        @(posedge z80_clk);
        @(negedge eclk);
        ab = {8'h00, BASE + 8'd1};
        iorq_n = 1'b0;
        rd_n = 1'b0;
        n = 0;
        while (wait_n == 1'b1 && n < LIMIT) begin
            @(negedge eclk);
            n++;
        end
        check("rst_wait_reached", 16'(n < LIMIT), 16'd1);
        check("rst_oe_before", 16'(db_oe), 16'd1);
        ereset = 1'b1;
        @(negedge eclk);
        check("rst_mid_wait", 16'(wait_n), 16'd1);
        check("rst_mid_oe", 16'(db_oe), 16'd0);
        check("rst_mid_int", 16'(int_n), 16'd1);
        check("rst_mid_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_mid_rx_ready", 16'(rx_ready), 16'd1);
        @(negedge eclk);
        ereset = 1'b0;
        model_reset();
        repeat (6) @(negedge eclk);
        check("inflight_wait", 16'(wait_n), 16'd1);
        check("inflight_oe", 16'(db_oe), 16'd0);
        iorq_n = 1'b1;
        rd_n = 1'b1;
        repeat (3) @(negedge eclk);
        do_read(2'd1);
        do_read(2'd2);
        do_read(2'd0);

        // Random operation mix.
        for (int it = 0; it < 70; it++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: do_write(2'd0, 8'($urandom));
                2:    do_read(2'd1);
                3:    do_write(2'd1, 8'($urandom));
                4:    do_write(2'd2, 8'($urandom));
                5:    do_read(2'd2);
                6:    rx_send(8'($urandom));
                7:    do_read(2'd0);
                8:    drain();
                default: bus(1'($urandom), BASE + 8'(3 + $urandom_range(0, 252)), 8'($urandom), r);
            endcase
            check_int();
        end
        drain();
        do_read(2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_io_responder.md
# z80_io_responder

Z80 I/O-space responder for the test SoC: the peripheral end of the Z80 bus opposite the `chip_z80` initiator. It decodes IN/OUT cycles at a configurable port base and exposes a byte-stream console, with TX toward the bench and RX from the bench. It also inserts programmable wait states and answers interrupt-acknowledge (mode-2 vector) cycles. It runs entirely in the `eclk` domain and samples the Z80 `clk` and bus strobes as levels.

## Interface
- BASE, 8'h10, I/O port base; the block decodes ab[7:0] in BASE..BASE+2.
- TX_DEPTH, 4, TX FIFO depth in bytes; must be a power of 2, minimum 2.
- WAIT_CYCLES, 1, number of extra Z80 clock rising edges that `_wait` is held low per decoded I/O access; 0 disables wait insertion.

Ports:
- eclk  in  1  system clock.
- ereset  in  1  synchronous, active-high reset.
- clk  in  1  Z80 clock level, sampled on eclk.
- ab  in  16  address bus.
- db_o  in  8  data driven by the CPU.
- db_i  out  8  data returned to the CPU.
- db_oe  out  1  high while the responder drives db_i.
- _iorq, _rd, _wr, _m1  in  1 each  Z80 strobes, active-low.
- _wait  out  1  wait request, active-low.
- _int  out  1  interrupt request, active-low.
- tx_data  out  8, tx_valid  out  1, tx_ready  in  1  TX stream toward the bench.
- rx_data  in  8, rx_valid  in  1, rx_ready  out  1  RX stream from the bench.

## Operation
- Every strobe and `clk` is registered once on eclk. Edges are detected against the previous registered value.
- An access is decoded on the first eclk where registered `_iorq`=0, `_m1`=1, and (`_rd`=0 or `_wr`=0), and ab[7:0] is in range. Out-of-range accesses are ignored: no wait, no drive.
- Register map:
  - BASE+0 DATA. Read returns the RX holding register. Write pushes db_o into the TX FIFO. A write while the FIFO is full drops the byte and sets OVF.
  - BASE+1 STATUS. Read bits: [0] rx_full, [1] tx_not_full, [2] tx_empty, [3] OVF (sticky), [4] int_en, [7:5] read 0. Write: bit4 loads int_en; writing 1 to bit3 clears OVF.
  - BASE+2 VECTOR, read/write 8 bits.
- Read side-effect: a DATA read clears rx_full on the access-end edge, not at decode, so a long read cannot pop twice.
- Write capture: db_o is captured on the registered rising edge of `_wr` while `_iorq` is still low.
- RX path:
  - rx_ready = !rx_full. A transfer occurs when rx_valid & rx_ready; it loads rx_data and sets rx_full.
  - If a DATA-read pop and an RX transfer fall on the same eclk, the new byte is loaded and rx_full stays 1.
- TX path: tx_valid = FIFO not empty; tx_data = FIFO head; the FIFO pops on tx_valid & tx_ready. A push into a full FIFO on the same eclk as a pop is still dropped and sets OVF.
- Interrupt: `_int` = !(int_en & rx_full).
- INTA cycle (`_m1`=0 & `_iorq`=0): drive VECTOR on db_i with db_oe=1 regardless of address, until `_iorq` rises. No side-effects and no wait.
- Wait FSM states:
  - IDLE → WAIT on a decoded access when WAIT_CYCLES>0, loading the counter with WAIT_CYCLES.
  - WAIT decrements on each registered `clk` rising edge and moves to HOLD when the counter reaches 0.
  - HOLD → IDLE when `_iorq` rises.
  - `_wait` is low only in WAIT.
  - If `_iorq` rises while in WAIT (aborted cycle), return to IDLE immediately.

## Timing
- Reset values: db_i=0, db_oe=0, _wait=1, _int=1, tx_valid=0, rx_ready=1, rx_full=0, OVF=0, int_en=0, VECTOR=0, FIFO empty, FSM IDLE.
- Read data and db_oe become valid 1 eclk after decode (2 eclk after the strobe edge at the pin). They are held until `_rd` or `_iorq` rises, and db_oe drops on that same eclk.
- `_wait` asserts 1 eclk after decode and releases 1 eclk after the WAIT_CYCLES-th registered `clk` rise.
- tx_valid rises 1 eclk after a write's capture edge. `_int` asserts 1 eclk after the rx_full set.
- ereset mid-access: all state returns to reset values, and the in-flight access is ignored until `_iorq` returns high and a new cycle begins.

## Structure
- Package `z80_io_pkg`: register offsets (REG_DATA=0, REG_STATUS=1, REG_VECTOR=2), STATUS bit indices, and the wait-FSM state enum.
- Sub-module `sync_fifo` (WIDTH=8, DEPTH=TX_DEPTH) with push/pop/full/empty. Pointers are one bit wider than log2(DEPTH) to distinguish full from empty.

## Test plan
- OUT (BASE),8'h41 with tx_ready=1 → tx_valid pulse with tx_data=8'h41; STATUS reads 8'h06.
- 5 OUTs to DATA with tx_ready=0 and TX_DEPTH=4 → the 5th byte is dropped and STATUS=8'h08 (full, OVF set). Write 8'h08 to STATUS → OVF clears. Release tx_ready → exactly 4 bytes drain in order.
- Bench sends 8'h5A with int_en=1 → _int low and rx_ready=0. IN (BASE) returns 8'h5A; after _rd rises, _int=1 and rx_ready=1.
- VECTOR=8'hE0, then a forced INTA cycle → db_i=8'hE0 with db_oe=1 for the duration of _iorq low; no state change.
- WAIT_CYCLES=3 → _wait low for exactly 3 Z80 clk rises on an in-range IN; no _wait on IN (BASE+3).
- ereset asserted during the WAIT state → _wait=1 and db_oe=0 on the next eclk, and all registers return to reset values.
